// File: rtl/uart_rx_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Purpose  : Shared constants and types for the UART receive byte buffer.
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int UART_BYTE_W  = 8;
    localparam int DEF_DEPTH    = 16;
    localparam int DEF_RTS_HIGH = 12;
    localparam int DEF_RTS_LOW  = 4;

    typedef enum logic {
        RTS_ACCEPT = 1'b0,
        RTS_HOLD   = 1'b1
    } rts_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_rx_fifo_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_fifo_if
// Purpose  : Receiver-side capture signals and FWFT read port of the buffer.
// Revision : 1.0 - initial release
// ============================================================================
interface uart_rx_fifo_if
    import uart_pkg::*;
();

    logic [UART_BYTE_W-1:0] in_data;
    logic                   in_valid;
    logic                   in_error;
    logic [UART_BYTE_W-1:0] out_data;
    logic                   out_valid;
    logic                   out_ready;

    modport master (
        output in_data,
        output in_valid,
        output in_error,
        output out_ready,
        input  out_data,
        input  out_valid
    );

    modport slave (
        input  in_data,
        input  in_valid,
        input  in_error,
        input  out_ready,
        output out_data,
        output out_valid
    );

endinterface
`default_nettype wire

// File: rtl/uart_rx_fifo_sync_edge.sv
`default_nettype none
// ============================================================================
// Module   : sync_edge
// Purpose  : Two-flop synchroniser followed by a one-cycle rising-edge pulse.
// Revision : 1.0 - initial release
// ============================================================================
module sync_edge #(
    parameter logic RESET_VAL = 1'b1
) (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic i_async,
    output logic      o_pulse
);

    logic r_meta;
    logic r_sync;
    logic r_hist;

    // Resetting to RESET_VAL keeps a level already high at release from looking new.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
            r_hist <= RESET_VAL;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_hist <= r_sync;
        end
    end

    assign o_pulse = r_sync & ~r_hist;

endmodule
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_fifo
// Purpose  : Synchronised byte capture into a FWFT FIFO with RTS hysteresis.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH    = DEF_DEPTH,
    parameter int ADDR_W   = 4,
    parameter int RTS_HIGH = DEF_RTS_HIGH,
    parameter int RTS_LOW  = DEF_RTS_LOW
) (
    input  wire logic        clk,
    input  wire logic        reset,
    input  wire logic        clear,
    uart_rx_fifo_if.slave    bus,
    output logic [ADDR_W:0]  count,
    output logic             rts,
    output logic             overflow,
    output logic             rx_error
);

    localparam logic [ADDR_W:0] c_DEPTH    = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] c_RTS_HIGH = (ADDR_W+1)'(RTS_HIGH);
    localparam logic [ADDR_W:0] c_RTS_LOW  = (ADDR_W+1)'(RTS_LOW);

    logic [UART_BYTE_W-1:0] r_mem [DEPTH];
    logic [ADDR_W-1:0]      r_wptr;
    logic [ADDR_W-1:0]      r_rptr;
    logic [ADDR_W:0]        r_count;
    logic                   r_out_valid;
    logic [UART_BYTE_W-1:0] r_out_data;
    logic                   r_overflow;
    logic                   r_rx_error;
    rts_state_t             r_rts_state;
    logic                   r_rts;

    logic                   w_push_pulse;
    logic                   w_err_pulse;
    logic                   w_full;
    logic                   w_pop;
    logic                   w_push;
    logic                   w_drop;
    logic                   w_wr_en;
    logic [ADDR_W-1:0]      w_rptr_next;
    logic [ADDR_W:0]        w_after_pop;
    logic [ADDR_W:0]        w_count_next;

    sync_edge #(.RESET_VAL(1'b1)) u_sync_valid (
        .clk     (clk),
        .reset   (reset),
        .i_async (bus.in_valid),
        .o_pulse (w_push_pulse)
    );

    sync_edge #(.RESET_VAL(1'b1)) u_sync_error (
        .clk     (clk),
        .reset   (reset),
        .i_async (bus.in_error),
        .o_pulse (w_err_pulse)
    );

    // A pop when full frees the slot the incoming byte lands in.
    assign w_full       = (r_count == c_DEPTH);
    assign w_pop        = r_out_valid & bus.out_ready;
    assign w_push       = w_push_pulse & (~w_full | w_pop);
    assign w_drop       = w_push_pulse & w_full & ~w_pop;
    assign w_wr_en      = w_push & reset & ~clear;
    assign w_rptr_next  = r_rptr + ADDR_W'(w_pop);
    assign w_after_pop  = r_count - (ADDR_W+1)'(w_pop);
    assign w_count_next = w_after_pop + (ADDR_W+1)'(w_push);

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wptr] <= bus.in_data;
        end
    end

    // The head register only sees entries written on earlier edges, so out_valid trails the write.
    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_overflow  <= 1'b0;
            r_rx_error  <= 1'b0;
        end else begin
            r_wptr      <= r_wptr + ADDR_W'(w_push);
            r_rptr      <= w_rptr_next;
            r_count     <= w_count_next;
            r_out_valid <= (w_after_pop != '0);
            r_out_data  <= (w_after_pop != '0) ? r_mem[w_rptr_next] : '0;
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            if (w_err_pulse) begin
                r_rx_error <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            r_rts_state <= RTS_ACCEPT;
            r_rts       <= 1'b0;
        end else begin
            case (r_rts_state)
                RTS_ACCEPT: begin
                    if (r_count >= c_RTS_HIGH) begin
                        r_rts_state <= RTS_HOLD;
                        r_rts       <= 1'b1;
                    end
                end
                RTS_HOLD: begin
                    if (r_count <= c_RTS_LOW) begin
                        r_rts_state <= RTS_ACCEPT;
                        r_rts       <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign count         = r_count;
    assign rts           = r_rts;
    assign overflow      = r_overflow;
    assign rx_error      = r_rx_error;

endmodule
`default_nettype wire

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Byte buffer directly downstream of the UART receiver.
- Captures each received byte from the receiver's data/strobe outputs and crosses them from the UART-clock domain into the system `clk` domain.
- Stores bytes in a 16-entry first-word-fall-through (FWFT) FIFO and presents them on a valid/ready read port.
- Drives low-asserted RTS with hysteresis so the remote sender pauses before overflow.

Parameters:
- DEPTH, 16, FIFO entries; must be a power of 2, at least 4.
- ADDR_W, 4, log2(DEPTH).
- RTS_HIGH, 12, count at or above which RTS is deasserted (driven 1).
- RTS_LOW, 4, count at or below which RTS is reasserted (driven 0); must satisfy RTS_LOW < RTS_HIGH ≤ DEPTH.

Ports:
- clk  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-low reset (0 = reset), sampled on rising clk.
- clear  in  1  synchronous flush, active high.
- in_data  in  8  received byte; quasi-static while in_valid is high.
- in_valid  in  1  asynchronous level from the receiver; a rising edge means a new byte.
- in_error  in  1  asynchronous level; framing error from the receiver.
- out_data  out  8  head-of-FIFO byte.
- out_valid  out  1  head byte is valid.
- out_ready  in  1  consumer accepts the head byte.
- count  out  ADDR_W+1  current occupancy, 0..DEPTH.
- rts  out  1  0 = sender may transmit; 1 = hold off.
- overflow  out  1  sticky: a byte was dropped.
- rx_error  out  1  sticky: a receiver error was seen.

Behaviour:
- Reset (reset=0 at a clk edge):
  - out_valid=0, out_data=0, count=0, rts=0, overflow=0, rx_error=0.
  - Read and write pointers = 0; RTS FSM = ACCEPT.
  - Synchroniser and edge-history flops reset to 1, so a level already high at reset release is not treated as a new byte.
- Priority each cycle: reset > clear > push/pop.
- clear=1 for one cycle gives the same result as reset, except the synchroniser flops keep running. No push or pop occurs in a clear cycle.
- Input crossing: in_valid and in_error each pass through a 2-flop synchroniser, then a rising-edge detector producing a 1-cycle pulse.
- Push:
  - On the push pulse, in_data is sampled directly; it is stable by then.
  - Latency from the in_valid rise to the FIFO write is 3 clk cycles.
  - out_valid rises on the cycle after the write, with no empty bypass.
- Pop: occurs when out_valid && out_ready. The next entry (if any) appears on out_data and out_valid on the following cycle.
- Simultaneous push and pop:
  - Both take effect and count is unchanged.
  - When full, the push is accepted because the pop frees a slot.
  - When empty, only the push takes effect (there is no valid head to pop).
- Full with push and no pop: the byte is dropped, overflow is set to 1 and stays set until reset or clear, and count stays at DEPTH.
- Pop while empty: impossible, because out_valid=0.
- Pointers: ADDR_W bits, wrapping modulo DEPTH. count tracks occupancy separately; full ⇔ count==DEPTH, empty ⇔ count==0.
- RTS FSM (evaluated on the registered count):
  - ACCEPT (rts=0) → HOLD when count ≥ RTS_HIGH.
  - HOLD (rts=1) → ACCEPT when count ≤ RTS_LOW.
  - Otherwise the state holds.
  - rts is the registered FSM output, so rts changes 1 cycle after count crosses a threshold.
- rx_error: set on the synchronised in_error rising-edge pulse; sticky until reset or clear. It does not affect the FIFO or rts.
- Mid-operation reset or clear: all stored bytes are discarded and a pending synchroniser pulse is dropped. A byte whose in_valid rose during reset is not pushed afterwards.

Decomposition:
- Shared package uart_pkg holds:
  - UART_BYTE_W=8.
  - RTS FSM state encodings RTS_ACCEPT=1'b0 and RTS_HOLD=1'b1.
  - Default DEPTH, RTS_HIGH and RTS_LOW constants.
- Sub-module sync_edge:
  - 2-flop synchroniser plus rising-edge pulse, with a reset value parameter.
  - Instantiated twice, for in_valid and in_error.
- Storage is a register array in the top module; no RAM macro is used.

Test Plan:
1. Release reset with in_valid low; toggle in_valid 0→1 with in_data=0x41 → out_valid=1 and out_data=0x41 exactly 4 cycles after the rise, count=1; pulse out_ready → count=0 and out_valid=0 on the next cycle.
2. Push 12 bytes 0x00..0x0B with out_ready=0 → rts goes 1 one cycle after count reaches 12. Then drain → rts stays 1 through counts 11..5 and returns to 0 one cycle after count reaches 4. Data pops in order 0x00..0x0B.
3. Push 17 bytes with no reads → count=16, overflow=1, 17th byte absent. Drain → 0x00..0x0F in order; overflow stays 1 until clear.
4. Fill to 16, then hold out_ready=1 while pushing 0x99 → 0x99 is accepted, count stays 16, overflow stays 0, and 0x99 pops last.
5. Hold in_valid high through reset release → no push and count=0. Raise in_error → rx_error=1 after 3 cycles; assert clear → rx_error=0, overflow=0, count=0, rts=0.
6. Assert reset for 1 cycle mid-drain at count=8 → all outputs return to reset values on the next cycle; the next in_valid rise is captured normally.
